// File: rtl/fifo_pkg.sv
// Shared width helpers for the VC FIFO bank and its per-channel FIFO.
package fifo_pkg;

  function automatic int unsigned vc_w_f(input int unsigned vc_num);
    return (vc_num > 1) ? $clog2(vc_num) : 1;
  endfunction

  function automatic int unsigned cnt_w_f(input int unsigned slots);
    return $clog2(slots + 1);
  endfunction

  function automatic int unsigned ptr_w_f(input int unsigned slots);
    return (slots > 1) ? $clog2(slots) : 1;
  endfunction

endpackage

// File: rtl/sync_gp_fifo.sv
// One FIFO channel: any-depth storage, wrap-by-compare pointers, occupancy counter and flags.
// Optional sticky overflow/underflow flags are built only when FIFO_ERR_FLAGS_EN is defined.
module sync_gp_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned SLOTS     = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned AFULL_THR = 3
) (
  input  logic                        clk,
  input  logic                        arst,
  input  logic                        wr_en_i,
  input  logic [WIDTH-1:0]            wr_data_i,
  input  logic                        rd_en_i,
  output logic                        full_o,
  output logic                        afull_o,
  output logic                        empty_o,
  output logic [WIDTH-1:0]            rd_data_o,
  output logic [cnt_w_f(SLOTS)-1:0]   cnt_o,
  output logic                        err_ovf_o,
  output logic                        err_udf_o
);

  localparam int unsigned PTR_W = ptr_w_f(SLOTS);
  localparam int unsigned CNT_W = cnt_w_f(SLOTS);

`ifndef NO_ASSERTIONS
  if (SLOTS < 2) begin : g_chk_slots
    $error("sync_gp_fifo: SLOTS must be >= 2");
  end
  if (AFULL_THR == 0 || AFULL_THR > SLOTS) begin : g_chk_afull
    $error("sync_gp_fifo: AFULL_THR must be in 1..SLOTS");
  end
`endif

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [SLOTS];
  logic             wr_acc, rd_acc;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SLOTS - 1)) ? '0 : p + 1'b1;
  endfunction

  // Flags decode registered count only, so enables never reach them combinationally.
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(SLOTS));
  assign afull_o = (cnt_q >= CNT_W'(AFULL_THR));
  assign cnt_o   = cnt_q;

  assign wr_acc = wr_en_i && !full_o;
  assign rd_acc = rd_en_i && !empty_o;

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_acc) wr_ptr_d = next_ptr(wr_ptr_q);
    if (rd_acc) rd_ptr_d = next_ptr(rd_ptr_q);
    unique case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data_i;
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d, udf_q, udf_d;

  assign ovf_d = ovf_q | (wr_en_i & full_o);
  assign udf_d = udf_q | (rd_en_i & empty_o);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign err_ovf_o = ovf_q;
  assign err_udf_o = udf_q;
`else
  assign err_ovf_o = 1'b0;
  assign err_udf_o = 1'b0;
`endif

endmodule

// File: rtl/sync_vc_fifo.sv
// Single-clock FIFO bank with one independent queue per virtual channel.
// Optional sticky error flags are enabled by defining FIFO_ERR_FLAGS_EN.
module sync_vc_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned VC_NUM    = 2,
  parameter int unsigned SLOTS     = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned AFULL_THR = 3
) (
  input  logic                                 clk,
  input  logic                                 arst,
  input  logic                                 wr_en_i,
  input  logic [vc_w_f(VC_NUM)-1:0]            wr_vc_i,
  input  logic [WIDTH-1:0]                     wr_data_i,
  output logic [VC_NUM-1:0]                    wr_full_o,
  output logic [VC_NUM-1:0]                    wr_afull_o,
  input  logic                                 rd_en_i,
  input  logic [vc_w_f(VC_NUM)-1:0]            rd_vc_i,
  output logic [WIDTH-1:0]                     rd_data_o,
  output logic [VC_NUM-1:0]                    rd_empty_o,
  output logic [VC_NUM*cnt_w_f(SLOTS)-1:0]     ocup_o,
  output logic [VC_NUM-1:0]                    err_ovf_o,
  output logic [VC_NUM-1:0]                    err_udf_o
);

  localparam int unsigned VC_W  = vc_w_f(VC_NUM);
  localparam int unsigned CNT_W = cnt_w_f(SLOTS);

`ifndef NO_ASSERTIONS
  if (VC_NUM < 1) begin : g_chk_vc
    $error("sync_vc_fifo: VC_NUM must be >= 1");
  end
`endif

  logic [VC_NUM-1:0] ch_wr_en;
  logic [VC_NUM-1:0] ch_rd_en;
  logic [WIDTH-1:0]  ch_rd_data [VC_NUM];

  // Out-of-range channel indices match no channel and are therefore ignored.
  for (genvar v = 0; v < VC_NUM; v++) begin : g_ch
    assign ch_wr_en[v] = wr_en_i && (wr_vc_i == VC_W'(v));
    assign ch_rd_en[v] = rd_en_i && (rd_vc_i == VC_W'(v));

    sync_gp_fifo #(
      .SLOTS     (SLOTS),
      .WIDTH     (WIDTH),
      .AFULL_THR (AFULL_THR)
    ) u_fifo (
      .clk       (clk),
      .arst      (arst),
      .wr_en_i   (ch_wr_en[v]),
      .wr_data_i (wr_data_i),
      .rd_en_i   (ch_rd_en[v]),
      .full_o    (wr_full_o[v]),
      .afull_o   (wr_afull_o[v]),
      .empty_o   (rd_empty_o[v]),
      .rd_data_o (ch_rd_data[v]),
      .cnt_o     (ocup_o[v*CNT_W +: CNT_W]),
      .err_ovf_o (err_ovf_o[v]),
      .err_udf_o (err_udf_o[v])
    );
  end

  always_comb begin
    rd_data_o = '0;
    for (int unsigned v = 0; v < VC_NUM; v++) begin
      if (rd_vc_i == VC_W'(v)) rd_data_o = ch_rd_data[v];
    end
  end

endmodule

// File: tb/tb_sync_vc_fifo.sv
// Bench for sync_vc_fifo: per-channel queue model checked every cycle, plus directed literal checks.
module tb_sync_vc_fifo;

  localparam int VC_NUM    = 2;
  localparam int SLOTS     = 3;
  localparam int WIDTH     = 8;
  localparam int AFULL_THR = 3;
  localparam int CNT_W     = 2;

`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    arst = 1'b0;
  logic                    wr_en = 1'b0;
  logic                    wr_vc = 1'b0;
  logic [WIDTH-1:0]        wr_data = '0;
  logic                    rd_en = 1'b0;
  logic                    rd_vc = 1'b0;
  logic [VC_NUM-1:0]       wr_full, wr_afull, rd_empty, err_ovf, err_udf;
  logic [WIDTH-1:0]        rd_data;
  logic [VC_NUM*CNT_W-1:0] ocup;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  byte unsigned      mq [VC_NUM][$];
  logic [VC_NUM-1:0] m_ovf = '0;
  logic [VC_NUM-1:0] m_udf = '0;

  always #5 clk = ~clk;

  sync_vc_fifo #(
    .VC_NUM    (VC_NUM),
    .SLOTS     (SLOTS),
    .WIDTH     (WIDTH),
    .AFULL_THR (AFULL_THR)
  ) dut (
    .clk        (clk),
    .arst       (arst),
    .wr_en_i    (wr_en),
    .wr_vc_i    (wr_vc),
    .wr_data_i  (wr_data),
    .wr_full_o  (wr_full),
    .wr_afull_o (wr_afull),
    .rd_en_i    (rd_en),
    .rd_vc_i    (rd_vc),
    .rd_data_o  (rd_data),
    .rd_empty_o (rd_empty),
    .ocup_o     (ocup),
    .err_ovf_o  (err_ovf),
    .err_udf_o  (err_udf)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Queue model: acceptance decided from occupancy at the start of the cycle.
  always @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int v = 0; v < VC_NUM; v++) mq[v].delete();
      m_ovf = '0;
      m_udf = '0;
    end else begin
      int wv;
      int rv;
      bit w_ok;
      bit r_ok;
      wv   = int'(wr_vc);
      rv   = int'(rd_vc);
      w_ok = wr_en && (mq[wv].size() < SLOTS);
      r_ok = rd_en && (mq[rv].size() > 0);
      if (wr_en && !w_ok) m_ovf[wv] = 1'b1;
      if (rd_en && !r_ok) m_udf[rv] = 1'b1;
      if (r_ok) void'(mq[rv].pop_front());
      if (w_ok) mq[wv].push_back(byte'(wr_data));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int rv;
      for (int v = 0; v < VC_NUM; v++) begin
        chk($sformatf("empty[%0d]", v), 32'(rd_empty[v]), 32'(mq[v].size() == 0));
        chk($sformatf("full[%0d]", v),  32'(wr_full[v]),  32'(mq[v].size() == SLOTS));
        chk($sformatf("afull[%0d]", v), 32'(wr_afull[v]), 32'(mq[v].size() >= AFULL_THR));
        chk($sformatf("ocup[%0d]", v),  32'(ocup[v*CNT_W +: CNT_W]), 32'(mq[v].size()));
        chk($sformatf("ovf[%0d]", v),   32'(err_ovf[v]), ERR_EN ? 32'(m_ovf[v]) : 32'd0);
        chk($sformatf("udf[%0d]", v),   32'(err_udf[v]), ERR_EN ? 32'(m_udf[v]) : 32'd0);
      end
      rv = int'(rd_vc);
      chk("rd_data", 32'(rd_data), (mq[rv].size() != 0) ? 32'(mq[rv][0]) : 32'd0);
    end
  end

  task automatic drive(input bit we, input bit wv, input logic [7:0] wd, input bit re, input bit rv);
    wr_en   = we;
    wr_vc   = wv;
    wr_data = wd;
    rd_en   = re;
    rd_vc   = rv;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_empty"}, 32'(rd_empty), 32'h3);
    chk({tag, "_full"},  32'(wr_full),  32'h0);
    chk({tag, "_afull"}, 32'(wr_afull), 32'h0);
    chk({tag, "_ocup"},  32'(ocup),     32'h0);
    chk({tag, "_ovf"},   32'(err_ovf),  32'h0);
    chk({tag, "_udf"},   32'(err_udf),  32'h0);
    chk({tag, "_data"},  32'(rd_data),  32'h0);
  endtask

  task automatic pop_expect(input logic [7:0] exp, input string nm);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk(nm, 32'(rd_data), 32'(exp));
    tick();
  endtask

  initial begin
    #2 arst = 1'b1;
    #1 chk_en = 1'b1;
    tick();
    tick();
    arst = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk_reset_state("rst0");

    // Fill vc0, check flags, then overflow.
    drive(1'b1, 1'b0, 8'hA1, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 8'hA2, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("afull_at2", 32'(wr_afull), 32'h0);
    drive(1'b1, 1'b0, 8'hA3, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("fill_ocup",  32'(ocup),     32'h3);
    chk("fill_full",  32'(wr_full),  32'h1);
    chk("fill_afull", 32'(wr_afull), 32'h1);
    chk("fill_empty", 32'(rd_empty), 32'h2);
    drive(1'b1, 1'b0, 8'hA4, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("ovf_ocup", 32'(ocup), 32'h3);
    chk("ovf_flag", 32'(err_ovf), ERR_EN ? 32'h1 : 32'h0);
    pop_expect(8'hA1, "pop_a1");
    pop_expect(8'hA2, "pop_a2");
    pop_expect(8'hA3, "pop_a3");
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("drain_empty", 32'(rd_empty), 32'h3);
    chk("drain_data",  32'(rd_data),  32'h0);

    // Second pass with pointers offset so both wrap mid-sequence.
    drive(1'b1, 1'b0, 8'hB1, 1'b0, 1'b0); tick();
    pop_expect(8'hB1, "pop_b1");
    drive(1'b1, 1'b0, 8'hB2, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 8'hB3, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 8'hB4, 1'b0, 1'b0); tick();

    // Full channel with simultaneous read and write: only the read is taken.
    drive(1'b1, 1'b0, 8'hC5, 1'b1, 1'b0);
    chk("fullrw_data", 32'(rd_data), 32'hB2);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("fullrw_ocup", 32'(ocup),    32'h2);
    chk("fullrw_full", 32'(wr_full), 32'h0);
    pop_expect(8'hB3, "pop_b3");
    pop_expect(8'hB4, "pop_b4");

    // Empty channel with simultaneous read and write: only the write is taken.
    drive(1'b1, 1'b0, 8'hD7, 1'b1, 1'b0);
    chk("emptyrw_data", 32'(rd_data), 32'h0);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("emptyrw_next", 32'(rd_data), 32'hD7);
    chk("emptyrw_ocup", 32'(ocup),    32'h1);
    chk("udf_flag",     32'(err_udf), ERR_EN ? 32'h1 : 32'h0);

    // Cross-channel write and read in the same cycle.
    drive(1'b1, 1'b1, 8'h22, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 8'h11, 1'b1, 1'b1);
    chk("xch_data", 32'(rd_data), 32'h22);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("xch_ocup",  32'(ocup),     32'h2);
    chk("xch_empty", 32'(rd_empty), 32'h2);
    pop_expect(8'hD7, "pop_d7");
    pop_expect(8'h11, "pop_11");

    // Randomised traffic with alternating fill/drain bias and occasional resets.
    for (int i = 0; i < 10000; i++) begin
      int wpct;
      wpct = ((i / 400) % 2 == 0) ? 70 : 30;
      drive($urandom_range(99) < wpct, 1'($urandom), 8'($urandom),
            $urandom_range(99) < (100 - wpct), 1'($urandom));
      if ($urandom_range(1999) == 0) begin
        arst = 1'b1;
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        arst = 1'b0;
      end
      tick();
    end

    // Reset pulse in the middle of traffic.
    drive(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 8'h6B, 1'b1, 1'b0);
    arst = 1'b1;
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    arst = 1'b0;
    tick();
    chk_reset_state("rst1");

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
